// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_t        - frame FSM state encoding (IDLE, START, DATA, STOP)
//   DEFAULT_DATA_BITS   - default data bits per frame
//   DEFAULT_OVERSAMPLE  - default Tick pulses per bit period
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous Rx line, plus one
// further delay stage used for falling-edge detection. All flops reset to 1
// (line idle) so that reset never looks like a start edge.
//   Clock   in  system clock
//   ResetN  in  asynchronous, active-low reset
//   Rx      in  raw serial input
//   RxSync  out Rx after two Clock flops
//   RxPrev  out RxSync delayed by one Clock
module uart_rx_sync (
  input  logic Clock,
  input  logic ResetN,
  input  logic Rx,
  output logic RxSync,
  output logic RxPrev
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= Rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign RxSync = sync_q;
  assign RxPrev = prev_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: UART receive path. Deserialises frames of 1 start bit (0),
// DATA_BITS data bits LSB first and 1 stop bit (1), using the 16x-baud Tick
// shared with the transmitter. Each bit is sampled in its middle.
//   Clock       in  system clock
//   ResetN      in  asynchronous, active-low reset
//   Tick        in  one-Clock pulse at OVERSAMPLE x baud
//   Rx          in  asynchronous serial input, idles high
//   DataOut     out last received word, held until the next frame completes
//   RxDone      out one-Clock strobe when DataOut/FrameError update
//   FrameError  out stop sample of the last frame was 0
//   RxBusy      out receiver is not idle
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS      = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE     = DEFAULT_OVERSAMPLE,
  parameter int STOP_BIT_TICKS = 16
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Tick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 RxDone,
  output logic                 FrameError,
  output logic                 RxBusy
);

  localparam int MAX_TICKS = (OVERSAMPLE > STOP_BIT_TICKS) ? OVERSAMPLE : STOP_BIT_TICKS;
  localparam int TW        = $clog2(MAX_TICKS);
  localparam int BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BIT_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  logic rx_sync;
  logic rx_prev;

  uart_rx_sync u_sync (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Rx     (Rx),
    .RxSync (rx_sync),
    .RxPrev (rx_prev)
  );

  uart_state_t          state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic                 busy_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Edge-triggered arm: a line held low (break) cannot restart a frame.
        if (rx_prev && !rx_sync) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (Tick) begin
          if (tick_q == HALF_LAST) begin
            if (!rx_sync) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (Tick) begin
          if (tick_q == BIT_LAST) begin
            shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == DATA_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (Tick) begin
          if (tick_q == STOP_LAST) begin
            data_d  = shift_q;
            ferr_d  = ~rx_sync;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      // Registered from the next state so RxBusy tracks state_q exactly.
      busy_q  <= (state_d != IDLE);
    end
  end

  assign DataOut    = data_q;
  assign RxDone     = done_q;
  assign FrameError = ferr_q;
  assign RxBusy     = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int TICK_DIV = 24;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       Clock;
  logic       ResetN;
  logic       Tick;
  logic       Rx;
  logic [7:0] DataOut;
  logic       RxDone;
  logic       FrameError;
  logic       RxBusy;

  uart_receiver #(
    .DATA_BITS      (8),
    .OVERSAMPLE     (16),
    .STOP_BIT_TICKS (16)
  ) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .Tick       (Tick),
    .Rx         (Rx),
    .DataOut    (DataOut),
    .RxDone     (RxDone),
    .FrameError (FrameError),
    .RxBusy     (RxBusy)
  );

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  initial begin
    int tcnt;
    tcnt = 0;
    Tick = 1'b0;
    forever begin
      @(negedge Clock);
      tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
      Tick = (tcnt == 0);
    end
  end

  // Scoreboard monitor: every RxDone pops one expected result.
  always @(negedge Clock) begin
    if (ResetN) begin
      if (RxDone) begin
        exp_t e;
        n_done++;
        chk("rxdone_width", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rxdone: got DataOut %0h FrameError %0b, none expected at %0t",
                   DataOut, FrameError, $time);
        end else begin
          e = sb.pop_front();
          chk("dataout", {24'd0, DataOut}, {24'd0, e.data});
          chk("frameerror", {31'd0, FrameError}, {31'd0, e.ferr});
        end
      end
      prev_done = RxDone;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    Rx = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic fe);
    exp_t e;
    e.data = d;
    e.ferr = fe;
    sb.push_back(e);
  endtask

  initial begin
    int base;
    vecs[0] = '{data: 8'h55, stop: 1'b1, gap: 1'b1, exp_data: 8'h55, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, gap: 1'b1, exp_data: 8'hA3, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h0F, stop: 1'b1, gap: 1'b0, exp_data: 8'h0F, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hC4, stop: 1'b0, gap: 1'b1, exp_data: 8'hC4, exp_ferr: 1'b1};
    vecs[4] = '{data: 8'h12, stop: 1'b1, gap: 1'b1, exp_data: 8'h12, exp_ferr: 1'b0};

    Rx = 1'b1;
    ResetN = 1'b0;
    wait_clks(5);
    chk("reset_dataout", {24'd0, DataOut}, 32'd0);
    chk("reset_rxdone", {31'd0, RxDone}, 32'd0);
    chk("reset_frameerror", {31'd0, FrameError}, 32'd0);
    chk("reset_rxbusy", {31'd0, RxBusy}, 32'd0);
    ResetN = 1'b1;
    wait_clks(BIT_CLKS);

    // Table-driven frames: good, back-to-back, bad stop, recovery.
    base = n_done;
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].gap) send_bit(1'b1);
      push_exp(vecs[i].exp_data, vecs[i].exp_ferr);
      send_frame(vecs[i].data, vecs[i].stop);
    end
    send_bit(1'b1);
    chk("table_done_count", n_done - base, 32'd5);

    // Glitch: low for 4 Ticks then high -> back to IDLE, no RxDone.
    base = n_done;
    Rx = 1'b0;
    wait_clks(4 * TICK_DIV);
    chk("glitch_busy_high", {31'd0, RxBusy}, 32'd1);
    Rx = 1'b1;
    wait_clks(9 * TICK_DIV + 4 - 4 * TICK_DIV);
    chk("glitch_busy_low", {31'd0, RxBusy}, 32'd0);
    wait_clks(BIT_CLKS * 2);
    chk("glitch_no_done", n_done - base, 32'd0);

    // Break: Rx low 20 bit times -> one frame 0x00 with FrameError.
    base = n_done;
    push_exp(8'h00, 1'b1);
    Rx = 1'b0;
    wait_clks(20 * BIT_CLKS);
    chk("break_done_count", n_done - base, 32'd1);
    chk("break_idle", {31'd0, RxBusy}, 32'd0);
    send_bit(1'b1);
    push_exp(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1);
    send_bit(1'b1);
    chk("after_break_count", n_done - base, 32'd2);

    // Reset in the middle of DATA of 0x7E: abandoned, no RxDone.
    base = n_done;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("midframe_busy", {31'd0, RxBusy}, 32'd1);
    ResetN = 1'b0;
    Rx = 1'b1;
    #1;
    chk("midreset_dataout", {24'd0, DataOut}, 32'd0);
    chk("midreset_rxdone", {31'd0, RxDone}, 32'd0);
    chk("midreset_frameerror", {31'd0, FrameError}, 32'd0);
    chk("midreset_rxbusy", {31'd0, RxBusy}, 32'd0);
    wait_clks(4);
    ResetN = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("midreset_no_done", n_done - base, 32'd0);
    push_exp(8'h81, 1'b0);
    send_frame(8'h81, 1'b1);
    send_bit(1'b1);
    chk("after_reset_count", n_done - base, 32'd1);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
